mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Multi-cycle iterative multiplier for the MIPS pipeline EX stage; executes mult/multu and holds the HI/LO pair read by mfhi/mflo.
- Produces mult_done, consumed by the hazard detector to stall F/D while a multiply is outstanding.
- Also services mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits (HI = upper WIDTH, LO = lower WIDTH).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_e  input  1  mult/multu in EX this cycle.
- signed_e  input  1  1 = mult (two's complement), 0 = multu.
- srca_e  input  WIDTH  rs operand.
- srcb_e  input  WIDTH  rt operand.
- flush_e  input  1  EX flush/squash; aborts the multiply.
- hiwrite_e  input  1  mthi.
- lowrite_e  input  1  mtlo.
- wd_e  input  WIDTH  mthi/mtlo data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- mult_done  output  1  1 = no multiply in flight; 0 = busy.

Behaviour:
- Reset (async, reset_n low): state=IDLE, hi=0, lo=0, count=0, internal accumulator/operands=0, mult_done=1. Reset mid-RUN aborts immediately.
- States:
  - IDLE: mult_done=1.
  - RUN: mult_done=0.
- IDLE->RUN: on a clk edge with start_e=1 and flush_e=0. Capture the operands as magnitudes: if signed_e, take |srca_e| and |srcb_e|, and latch neg = sign(a) XOR sign(b); else capture raw values with neg=0. |-2^(WIDTH-1)| = 2^(WIDTH-1), held as unsigned WIDTH bits. Clear the 2*WIDTH accumulator; count=0.
- RUN iteration, once per cycle, shift-add radix-2: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift the multiplier right and the multiplicand left; count++.
- RUN->IDLE: on the edge where count reaches WIDTH, i.e. WIDTH cycles after the start edge.
  - Same edge: {hi,lo} <= neg ? -acc : acc; mult_done returns to 1.
- Latency: start sampled at edge N; mult_done low after N through N+WIDTH-1; hi/lo valid and mult_done=1 after edge N+WIDTH.
- start_e while in RUN: ignored; the hazard logic must stall.
- flush_e while in RUN: abort at the next edge, go to IDLE, hi/lo unchanged, mult_done=1.
- flush_e and start_e together in IDLE: flush wins; no multiply starts.
- hiwrite_e/lowrite_e in IDLE (no start): hi/lo <= wd_e at the edge. Both asserted writes both.
- Write priority:
  - In RUN: writes ignored.
  - Same cycle as start_e: start wins and the write is dropped.
- hi/lo are plain register outputs; there is no combinational path from inputs.
- All arithmetic is unsigned on 2*WIDTH bits. Final negation is two's complement on 2*WIDTH bits. Overflow cannot occur.

Optional Feature:
- Macro: MULT_RADIX4_EN.
- Defined: each RUN cycle retires 2 multiplier bits (adds 0, 1x, 2x or 3x the multiplicand, with 3x precomputed at capture). Shifts are by 2; RUN lasts WIDTH/2 cycles (16 at default). WIDTH must be even. All other rules are unchanged.
- Undefined: radix-2, WIDTH cycles.

Test Plan:
- multu 0xFFFFFFFF * 0xFFFFFFFF, start at edge N -> mult_done=0 through edge N+31; after edge N+32, hi=0xFFFFFFFE, lo=0x00000001, mult_done=1.
- mult -3 * 7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- mthi 0x12345678, mtlo 0x9ABCDEF0 in IDLE -> hi/lo updated next edge. Then start multu 5*6 and assert flush_e at RUN cycle 10 -> mult_done=1 next edge, hi/lo still 0x12345678/0x9ABCDEF0.
- In RUN, pulse start_e with new operands and pulse hiwrite_e -> both ignored; the result is for the original operands, 2*3 -> hi=0, lo=6.
- reset_n low at RUN cycle 20 -> immediately hi=0, lo=0, mult_done=1. A multu 1*1 after release -> lo=1 after WIDTH cycles.
- With MULT_RADIX4_EN: multu 0xFFFFFFFF*0xFFFFFFFF -> result as above after 16 cycles. start_e+flush_e together in IDLE -> mult_done stays 1, hi/lo unchanged.

Source files
------------

// File: rtl/mult_if.sv
// ---------------------------------------------------------------------------
// mult_if
//   EX-stage bundle between the pipeline and the iterative multiplier.
//
//   Pipeline -> multiplier (driven by the master):
//     start_e    mult/multu is in EX this cycle
//     signed_e   1 = mult (two's complement), 0 = multu
//     srca_e     rs operand
//     srcb_e     rt operand
//     flush_e    EX squash; aborts a multiply in flight
//     hiwrite_e  mthi
//     lowrite_e  mtlo
//     wd_e       mthi/mtlo data
//   Multiplier -> pipeline (driven by the slave):
//     hi, lo     HI/LO register pair
//     mult_done  1 = no multiply in flight, 0 = busy (stall F/D)
// ---------------------------------------------------------------------------
interface mult_if #(
  parameter int WIDTH = 32
);

  logic             start_e;
  logic             signed_e;
  logic [WIDTH-1:0] srca_e;
  logic [WIDTH-1:0] srcb_e;
  logic             flush_e;
  logic             hiwrite_e;
  logic             lowrite_e;
  logic [WIDTH-1:0] wd_e;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_done;

  modport master (
    output start_e, signed_e, srca_e, srcb_e, flush_e,
           hiwrite_e, lowrite_e, wd_e,
    input  hi, lo, mult_done
  );

  modport slave (
    input  start_e, signed_e, srca_e, srcb_e, flush_e,
           hiwrite_e, lowrite_e, wd_e,
    output hi, lo, mult_done
  );

endinterface

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
//   Multi-cycle shift-add multiplier for the MIPS EX stage. Executes
//   mult/multu, holds the HI/LO pair read by mfhi/mflo and services
//   mthi/mtlo writes.
//
//   The operands are reduced to magnitudes at capture, multiplied unsigned
//   on 2*WIDTH bits, and the product is negated at the end when the operand
//   signs differ (signed multiply only).
//
// Parameters:
//   WIDTH   operand width; product is 2*WIDTH bits (HI upper, LO lower)
//   CNT_W   iteration counter width
//
// Ports:
//   clk       pipeline clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       mult_if slave modport (operands, control, HI/LO, mult_done)
//
// Configuration:
//   MULT_RADIX4_EN  when defined, each RUN cycle retires two multiplier bits
//                   (RUN lasts WIDTH/2 cycles; WIDTH must be even). When
//                   undefined, radix-2 with WIDTH RUN cycles.
// ---------------------------------------------------------------------------
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset_n,
  mult_if.slave bus
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

`ifdef MULT_RADIX4_EN
  localparam int ITER = WIDTH / 2;
`else
  localparam int ITER = WIDTH;
`endif

  // Count value during the final RUN cycle; the edge that ends this cycle
  // brings the count to ITER and writes the product.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  logic [0:0]         state_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
`ifdef MULT_RADIX4_EN
  logic [2*WIDTH-1:0] mcand3_q;
`endif

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;
  logic               start_ok;

  // Operand magnitudes. The most negative value maps onto itself, which read
  // as unsigned is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_neg = bus.signed_e & bus.srca_e[WIDTH-1];
    b_neg = bus.signed_e & bus.srcb_e[WIDTH-1];
    a_mag = a_neg ? (~bus.srca_e + WIDTH'(1)) : bus.srca_e;
    b_mag = b_neg ? (~bus.srcb_e + WIDTH'(1)) : bus.srcb_e;
    a_ext = {{WIDTH{1'b0}}, a_mag};
  end

  // A squash in EX kills the multiply before it begins.
  assign start_ok = bus.start_e & ~bus.flush_e;

  // Partial product selected by the low multiplier bit(s) this cycle.
  always_comb begin
    partial = '0;
`ifdef MULT_RADIX4_EN
    unique case (mplier_q[1:0])
      2'b01:   partial = mcand_q;
      2'b10:   partial = {mcand_q[2*WIDTH-2:0], 1'b0};
      2'b11:   partial = mcand3_q;
      default: partial = '0;
    endcase
`else
    if (mplier_q[0]) begin
      partial = mcand_q;
    end
`endif
  end

  // The final product includes the last cycle's partial, so the sign fix-up
  // is applied to the accumulator value that is about to be formed.
  always_comb begin
    acc_next = acc_q + partial;
    product  = neg_q ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
  end

  // Control and datapath sequencing. In IDLE a start captures operands and
  // wins over any mthi/mtlo in the same cycle; otherwise the writes land.
  // In RUN a flush abandons the multiply without touching HI/LO, and
  // new starts and writes are ignored because the hazard unit stalls them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= STATE_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (start_ok) begin
            state_q  <= STATE_RUN;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= a_ext;
            mplier_q <= b_mag;
            neg_q    <= a_neg ^ b_neg;
`ifdef MULT_RADIX4_EN
            mcand3_q <= {a_ext[2*WIDTH-2:0], 1'b0} + a_ext;
`endif
          end else if (!bus.start_e) begin
            if (bus.hiwrite_e) begin
              hi_q <= bus.wd_e;
            end
            if (bus.lowrite_e) begin
              lo_q <= bus.wd_e;
            end
          end
        end

        STATE_RUN: begin
          if (bus.flush_e) begin
            state_q <= STATE_IDLE;
          end else begin
            acc_q   <= acc_next;
            count_q <= count_q + CNT_W'(1);
`ifdef MULT_RADIX4_EN
            mcand_q  <= {mcand_q[2*WIDTH-3:0], 2'b00};
            mcand3_q <= {mcand3_q[2*WIDTH-3:0], 2'b00};
            mplier_q <= {2'b00, mplier_q[WIDTH-1:2]};
`else
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`endif
            if (count_q == LAST_CNT) begin
              state_q <= STATE_IDLE;
              hi_q    <= product[2*WIDTH-1:WIDTH];
              lo_q    <= product[WIDTH-1:0];
            end
          end
        end

        default: begin
          state_q <= STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mult_done = (state_q == STATE_IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit
//   Directed bench for mult_unit: a table of multiply vectors with
//   hand-computed products, plus hand-written sequences for mthi/mtlo,
//   flush, start/write collisions and asynchronous reset mid-multiply.
// ---------------------------------------------------------------------------
module tb_mult_unit;

  localparam int WIDTH = 32;
`ifdef MULT_RADIX4_EN
  localparam int ITER = WIDTH / 2;
`else
  localparam int ITER = WIDTH;
`endif
  localparam int RST_WAIT = (ITER > 20) ? 19 : 9;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t vecs[11];

  mult_if #(.WIDTH(WIDTH)) bus ();

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running pipeline clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a wedged run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    bus.start_e   = 1'b0;
    bus.signed_e  = 1'b0;
    bus.srca_e    = '0;
    bus.srcb_e    = '0;
    bus.flush_e   = 1'b0;
    bus.hiwrite_e = 1'b0;
    bus.lowrite_e = 1'b0;
    bus.wd_e      = '0;
  endtask

  // Drives a start for one cycle; returns at the negedge after the start edge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b);
    bus.start_e  = 1'b1;
    bus.signed_e = sgn;
    bus.srca_e   = a;
    bus.srcb_e   = b;
    @(negedge clk);
    bus.start_e  = 1'b0;
  endtask

  // Confirms mult_done stays low for the given number of cycles.
  task automatic checkBusyWindow(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.mult_done !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  task automatic checkResult(input string name, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
    checkOutput({name, "_done"}, {31'b0, bus.mult_done}, 32'd1);
    checkOutput({name, "_hi"}, bus.hi, exp_hi);
    checkOutput({name, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E};
    vecs[4]  = '{1'b1, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[6]  = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[10] = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};

    idleInputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResult("reset", 32'h0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table of multiplies: exact busy window, then result.
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].sgn, vecs[v].a, vecs[v].b);
      checkBusyWindow($sformatf("vec%0d_busy", v), ITER);
      checkResult($sformatf("vec%0d", v), vecs[v].exp_hi, vecs[v].exp_lo);
    end

    // mthi then mtlo, each landing at the next edge.
    bus.hiwrite_e = 1'b1;
    bus.wd_e      = 32'h12345678;
    @(negedge clk);
    bus.hiwrite_e = 1'b0;
    checkOutput("mthi_hi", bus.hi, 32'h12345678);
    bus.lowrite_e = 1'b1;
    bus.wd_e      = 32'h9ABCDEF0;
    @(negedge clk);
    bus.lowrite_e = 1'b0;
    checkResult("mtlo", 32'h12345678, 32'h9ABCDEF0);

    // Flush during RUN cycle 10 leaves HI/LO untouched.
    applyStimulus(1'b0, 32'd5, 32'd6);
    checkBusyWindow("flush_busy", 9);
    bus.flush_e = 1'b1;
    @(negedge clk);
    bus.flush_e = 1'b0;
    checkResult("flush", 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    checkOutput("flush_stay_idle", {31'b0, bus.mult_done}, 32'd1);

    // Start and mthi pulsed mid-RUN are both ignored.
    applyStimulus(1'b0, 32'd2, 32'd3);
    checkBusyWindow("ignore_busy_a", 4);
    bus.start_e   = 1'b1;
    bus.srca_e    = 32'd9;
    bus.srcb_e    = 32'd9;
    bus.hiwrite_e = 1'b1;
    bus.wd_e      = 32'hDEADBEEF;
    @(negedge clk);
    idleInputs();
    checkBusyWindow("ignore_busy_b", ITER - 5);
    checkResult("ignore", 32'h0, 32'h6);

    // mthi and mtlo together write both halves.
    bus.hiwrite_e = 1'b1;
    bus.lowrite_e = 1'b1;
    bus.wd_e      = 32'h55AA55AA;
    @(negedge clk);
    idleInputs();
    checkResult("both_wr", 32'h55AA55AA, 32'h55AA55AA);

    // Asynchronous reset in the middle of RUN clears everything at once.
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkBusyWindow("rst_busy", RST_WAIT);
    #2;
    reset_n = 1'b0;
    #1;
    checkResult("async_rst", 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'd1, 32'd1);
    checkBusyWindow("post_rst_busy", ITER);
    checkResult("post_rst", 32'h0, 32'h1);

    // start and flush together in IDLE: nothing starts.
    bus.flush_e = 1'b1;
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bus.flush_e = 1'b0;
    checkResult("start_flush", 32'h0, 32'h1);
    @(negedge clk);
    checkOutput("start_flush_idle", {31'b0, bus.mult_done}, 32'd1);

    // mthi in the same cycle as a start is dropped.
    bus.hiwrite_e = 1'b1;
    bus.wd_e      = 32'hCAFEBABE;
    applyStimulus(1'b0, 32'd2, 32'd2);
    bus.hiwrite_e = 1'b0;
    checkBusyWindow("start_wr_busy", ITER);
    checkResult("start_wr", 32'h0, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
